// File: rtl/wb_arbiter.sv
// Two-master, one-slave round-robin arbiter for the 8-bit register bus.
// Each grant covers exactly one transfer; a silent slave is aborted after TIMEOUT cycles.
module wb_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] gnt_o
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_d;
  logic             last_gnt, last_gnt_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [7:0]       rdata, rdata_d;
  logic             stb_d, we_d;
  logic [7:0]       adr_d, dat_d;
  logic [1:0]       gnt_d;
  logic             ack0_d, ack1_d, err0_d, err1_d;
  logic             sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= '0;
      rdata    <= '0;
      s_stb_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_adr_o  <= '0;
      s_dat_o  <= '0;
      gnt_o    <= '0;
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
    end else begin
      state    <= state_d;
      last_gnt <= last_gnt_d;
      cnt      <= cnt_d;
      rdata    <= rdata_d;
      s_stb_o  <= stb_d;
      s_we_o   <= we_d;
      s_adr_o  <= adr_d;
      s_dat_o  <= dat_d;
      gnt_o    <= gnt_d;
      m0_ack_o <= ack0_d;
      m1_ack_o <= ack1_d;
      m0_err_o <= err0_d;
      m1_err_o <= err1_d;
    end
  end

  // Both masters share one read-data register; only the granted one qualifies it.
  assign m0_dat_o = rdata;
  assign m1_dat_o = rdata;

  always_comb begin
    state_d    = state;
    last_gnt_d = last_gnt;
    cnt_d      = cnt;
    rdata_d    = rdata;
    stb_d      = s_stb_o;
    we_d       = s_we_o;
    adr_d      = s_adr_o;
    dat_d      = s_dat_o;
    gnt_d      = gnt_o;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    sel        = 1'b0;

    case (state)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          // On a tie the master that was not served last wins.
          sel     = (m0_stb_i && m1_stb_i) ? ~last_gnt : m1_stb_i;
          we_d    = sel ? m1_we_i  : m0_we_i;
          adr_d   = sel ? m1_adr_i : m0_adr_i;
          dat_d   = sel ? m1_dat_i : m0_dat_i;
          gnt_d   = sel ? 2'b10 : 2'b01;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (s_ack_i) begin
          rdata_d = s_dat_i;
          stb_d   = 1'b0;
          ack0_d  = gnt_o[0];
          ack1_d  = gnt_o[1];
          state_d = RESP;
        end else if (cnt == CNT_LAST) begin
          rdata_d = 8'hFF;
          stb_d   = 1'b0;
          err0_d  = gnt_o[0];
          err1_d  = gnt_o[1];
          state_d = RESP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      RESP: begin
        last_gnt_d = gnt_o[1];
        gnt_d      = 2'b00;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single transfers, round-robin ties, timeout, ack/timeout race, reset abort.
module tb_wb_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [7:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic       s_stb_o, s_we_o, s_ack_i;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0] gnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called in IDLE with requests set; returns in RESP with the grant and strobe length seen.
  task automatic run_xfer(input int ack_at, input logic [7:0] rd,
                          output logic [1:0] g, output int n_stb);
    tick();
    g     = gnt_o;
    n_stb = 0;
    while (s_stb_o && n_stb < 40) begin
      n_stb++;
      if (n_stb == ack_at) begin
        s_ack_i = 1'b1;
        s_dat_i = rd;
      end
      tick();
      s_ack_i = 1'b0;
    end
  endtask

  logic [1:0] g;
  int         n_stb;
  logic [1:0] exp_g;

  initial begin
    rst_i = 1'b1;
    m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    s_ack_i = 0; s_dat_i = 0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    chk("rst_stb", s_stb_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_ack", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("rst_sadr", {s_adr_o, s_dat_o, s_we_o}, 0);
    chk("rst_rdat", m0_dat_o, 0);

    // 1: m0 write, ack on first XFER cycle
    m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 8'h21; m0_dat_i = 8'hA5;
    tick();
    chk("t1_stb", s_stb_o, 1);
    chk("t1_bus", {s_adr_o, s_dat_o, s_we_o}, {8'h21, 8'hA5, 1'b1});
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_noack", m0_ack_o, 0);
    m0_adr_i = 8'h77; m0_dat_i = 8'h00; m0_we_i = 0;
    s_ack_i = 1; s_dat_i = 8'h11;
    tick();
    s_ack_i = 0;
    chk("t1_ack", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b1000);
    chk("t1_stb_off", s_stb_o, 0);
    m0_stb_i = 0;
    tick();
    chk("t1_ack_pulse", m0_ack_o, 0);
    chk("t1_gnt_idle", gnt_o, 0);

    // 2: m1 read, slave acks in the 4th XFER cycle
    m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 8'h93; m1_dat_i = 8'h00;
    run_xfer(4, 8'h5C, g, n_stb);
    chk("t2_gnt", g, 2'b10);
    chk("t2_nstb", n_stb, 4);
    chk("t2_adr", s_adr_o, 8'h93);
    chk("t2_we", s_we_o, 0);
    chk("t2_ack", {m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}, 4'b1000);
    chk("t2_dat", m1_dat_o, 8'h5C);
    m1_stb_i = 0;
    tick();

    // 3: reset, then both request and re-request; grants must alternate from m0
    rst_i = 1; tick(); rst_i = 0;
    m0_stb_i = 1; m1_stb_i = 1;
    m0_adr_i = 8'h10; m1_adr_i = 8'h20;
    exp_g = 2'b01;
    for (int i = 0; i < 4; i++) begin
      run_xfer(1, 8'(i), g, n_stb);
      chk($sformatf("t3_gnt%0d", i), g, exp_g);
      chk($sformatf("t3_ack%0d", i), {m1_ack_o, m0_ack_o}, exp_g);
      if (g[0]) m0_stb_i = 0;
      if (g[1]) m1_stb_i = 0;
      tick();
      m0_stb_i = 1; m1_stb_i = 1;
      exp_g = {exp_g[0], exp_g[1]};
    end
    m0_stb_i = 0; m1_stb_i = 0;
    tick();

    // 4: slave never acks, then a normal transfer
    m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 8'h55;
    run_xfer(0, 8'h00, g, n_stb);
    chk("t4_nstb", n_stb, 15);
    chk("t4_err", {m0_err_o, m0_ack_o, m1_err_o, m1_ack_o}, 4'b1000);
    chk("t4_dat", m0_dat_o, 8'hFF);
    m0_stb_i = 0;
    tick();
    m0_stb_i = 1;
    run_xfer(1, 8'h3C, g, n_stb);
    chk("t4_next_ack", {m0_ack_o, m0_err_o}, 2'b10);
    chk("t4_next_dat", m0_dat_o, 8'h3C);
    m0_stb_i = 0;
    tick();

    // 5: ack arrives on the last allowed cycle
    m0_stb_i = 1;
    run_xfer(15, 8'h6A, g, n_stb);
    chk("t5_nstb", n_stb, 15);
    chk("t5_ack", {m0_ack_o, m0_err_o}, 2'b10);
    chk("t5_dat", m0_dat_o, 8'h6A);
    m0_stb_i = 0;
    tick();

    // 6: reset in the 2nd XFER cycle after m1 was served last
    m1_stb_i = 1;
    run_xfer(1, 8'h01, g, n_stb);
    m1_stb_i = 0;
    tick();
    m0_stb_i = 1;
    tick();
    tick();
    chk("t6_in_xfer", s_stb_o, 1);
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("t6_stb", s_stb_o, 0);
    chk("t6_gnt", gnt_o, 0);
    chk("t6_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
    m1_stb_i = 1;
    tick();
    chk("t6_tie_gnt", gnt_o, 2'b01);
    chk("t6_resp2", {m0_ack_o, m0_err_o}, 0);
    s_ack_i = 1; s_dat_i = 8'h99;
    tick();
    s_ack_i = 0;
    chk("t6_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    m0_stb_i = 0; m1_stb_i = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
